// File: rtl/noc_input_vc_buffer_if.sv
// Flit handshake bundle between the router input stage and the output block.
// The slave side is the input stage; the master side is its environment.
interface noc_input_vc_buffer_if #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 64
);
  logic [CHANNELS-1:0]   i_valid;
  logic [DATA_WIDTH-1:0] i_flit;
  logic [CHANNELS-1:0]   o_vc_ready;
  logic [CHANNELS-1:0]   o_valid;
  logic [DATA_WIDTH-1:0] o_flit;
  logic [4:0]            o_port_req;
  logic                  i_ready;

  modport master (
    output i_valid, i_flit, i_ready,
    input  o_vc_ready, o_valid, o_flit, o_port_req
  );

  modport slave (
    input  i_valid, i_flit, i_ready,
    output o_vc_ready, o_valid, o_flit, o_port_req
  );
endinterface

// File: rtl/noc_input_vc_buffer.sv
// Router input stage: per-VC flit FIFOs, XY route on head flits, and a
// round-robin arbiter that holds the winning VC until its packet's tail leaves.
module noc_input_vc_buffer #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int THRESHOLD  = DEPTH - 2,
  parameter int COORD_W    = 4
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst,
  input  logic [COORD_W-1:0]    i_cur_x,
  input  logic [COORD_W-1:0]    i_cur_y,
  noc_input_vc_buffer_if.slave  bus,
  output logic                  o_error
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int VC_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  logic [CHANNELS-1:0][DATA_WIDTH-1:0] head;
  logic [CHANNELS-1:0][CNT_W-1:0]      count;
  logic [CHANNELS-1:0]                 not_empty, is_head, is_tail, eligible;
  logic [CHANNELS-1:0]                 pop, drop;

  state_t            state_reg, state_next;
  logic [VC_W-1:0]   lock_vc_reg, lock_vc_next;
  logic [VC_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [VC_W-1:0]   held_vc_reg, held_vc_next;
  logic              held_reg, held_next;
  logic [4:0]        port_reg, port_next;
  logic              error_reg, error_next;

  logic [VC_W-1:0]       sel_vc, cur_vc;
  logic                  sel_ok, cur_ok;
  logic [CHANNELS-1:0]   valid_vec;
  logic [4:0]            port_req;
  logic [DATA_WIDTH-1:0] flit_out;

  function automatic logic [4:0] route(input logic [DATA_WIDTH-1:0] flit,
                                       input logic [COORD_W-1:0]    cx,
                                       input logic [COORD_W-1:0]    cy);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    dx = flit[DATA_WIDTH-3 -: COORD_W];
    dy = flit[DATA_WIDTH-3-COORD_W -: COORD_W];
    if (dx > cx)      return 5'b00010;
    else if (dx < cx) return 5'b00100;
    else if (dy > cy) return 5'b01000;
    else if (dy < cy) return 5'b10000;
    else              return 5'b00001;
  endfunction

  function automatic logic [VC_W-1:0] rr_index(input logic [VC_W-1:0] base,
                                               input int              offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= CHANNELS) sum = sum - CHANNELS;
    return VC_W'(sum);
  endfunction

  // Per-VC FIFO; a pop in the same cycle frees the slot a full-FIFO write needs.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_vc
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
      logic [CNT_W-1:0]      cnt_reg;
      logic                  full, wr_en;

      assign full  = (cnt_reg == CNT_W'(DEPTH));
      assign wr_en = bus.i_valid[gi] && (!full || pop[gi]);

      always_ff @(posedge noc_clk) begin
        if (wr_en) mem[wr_ptr_reg] <= bus.i_flit;
      end

      always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          cnt_reg    <= '0;
        end else begin
          if (wr_en)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
          cnt_reg <= cnt_reg + CNT_W'(wr_en) - CNT_W'(pop[gi]);
        end
      end

      assign head[gi]      = mem[rd_ptr_reg];
      assign count[gi]     = cnt_reg;
      assign not_empty[gi] = (cnt_reg != '0);
      // Type encoding: bit DW-2 marks a head, bit DW-1 marks a tail.
      assign is_head[gi]   = head[gi][DATA_WIDTH-2];
      assign is_tail[gi]   = head[gi][DATA_WIDTH-1];
      assign eligible[gi]  = not_empty[gi] && is_head[gi];
      assign drop[gi]      = bus.i_valid[gi] && full && !pop[gi];
      assign bus.o_vc_ready[gi] = (cnt_reg < CNT_W'(THRESHOLD));
    end
  endgenerate

  // Later iterations overwrite earlier ones, so the smallest offset from rr_ptr wins.
  always_comb begin
    sel_vc = '0;
    sel_ok = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (eligible[rr_index(rr_ptr_reg, i)]) begin
        sel_vc = rr_index(rr_ptr_reg, i);
        sel_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    lock_vc_next = lock_vc_reg;
    rr_ptr_next  = rr_ptr_reg;
    held_next    = held_reg;
    held_vc_next = held_vc_reg;
    port_next    = port_reg;
    error_next   = error_reg | (|drop);
    pop          = '0;
    valid_vec    = '0;
    port_req     = '0;
    flit_out     = '0;
    cur_vc       = '0;
    cur_ok       = 1'b0;

    case (state_reg)
      IDLE: begin
        // Stray body/tail flits with no open packet are flushed.
        pop = not_empty & ~is_head;
        if (|pop) error_next = 1'b1;
        if (held_reg) begin
          cur_vc = held_vc_reg;
          cur_ok = 1'b1;
        end else begin
          cur_vc = sel_vc;
          cur_ok = sel_ok;
        end
        if (cur_ok) begin
          valid_vec[cur_vc] = 1'b1;
          port_req          = route(head[cur_vc], i_cur_x, i_cur_y);
          flit_out          = head[cur_vc];
          if (bus.i_ready) begin
            pop[cur_vc] = 1'b1;
            rr_ptr_next = rr_index(cur_vc, 1);
            held_next   = 1'b0;
            if (!is_tail[cur_vc]) begin
              state_next   = LOCKED;
              lock_vc_next = cur_vc;
              port_next    = port_req;
            end
          end else begin
            held_next    = 1'b1;
            held_vc_next = cur_vc;
          end
        end
      end

      LOCKED: begin
        port_req = port_reg;
        if (not_empty[lock_vc_reg]) begin
          valid_vec[lock_vc_reg] = 1'b1;
          flit_out               = head[lock_vc_reg];
          if (is_head[lock_vc_reg]) error_next = 1'b1;
          if (bus.i_ready) begin
            pop[lock_vc_reg] = 1'b1;
            rr_ptr_next      = rr_index(lock_vc_reg, 1);
            if (is_tail[lock_vc_reg] && !is_head[lock_vc_reg]) state_next = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state_reg   <= IDLE;
      lock_vc_reg <= '0;
      rr_ptr_reg  <= '0;
      held_reg    <= 1'b0;
      held_vc_reg <= '0;
      port_reg    <= '0;
      error_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lock_vc_reg <= lock_vc_next;
      rr_ptr_reg  <= rr_ptr_next;
      held_reg    <= held_next;
      held_vc_reg <= held_vc_next;
      port_reg    <= port_next;
      error_reg   <= error_next;
    end
  end

  assign bus.o_valid    = valid_vec;
  assign bus.o_flit     = flit_out;
  assign bus.o_port_req = port_req;
  assign o_error        = error_reg;
endmodule

// File: tb/tb_noc_input_vc_buffer.sv
// Directed bench for noc_input_vc_buffer: expected transfers are queued as
// stimulus is planned and checked by a monitor as the DUT hands flits over.
module tb_noc_input_vc_buffer;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  typedef struct packed {
    logic [63:0] flit;
    logic [1:0]  vc;
    logic [4:0]  port;
  } exp_t;

  logic       noc_clk = 1'b0;
  logic       noc_rst;
  logic [3:0] cur_x, cur_y;
  logic       error;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  noc_input_vc_buffer_if #(.CHANNELS(2), .DATA_WIDTH(64)) bus ();

  noc_input_vc_buffer dut (
    .noc_clk (noc_clk),
    .noc_rst (noc_rst),
    .i_cur_x (cur_x),
    .i_cur_y (cur_y),
    .bus     (bus),
    .o_error (error)
  );

  always #5 noc_clk = ~noc_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] mk(input logic [1:0] t, input logic [3:0] dx,
                                     input logic [3:0] dy, input logic [53:0] pl);
    return {t, dx, dy, pl};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic wr(input int vc, input logic [63:0] f);
    logic [1:0] v;
    v = '0;
    v[vc] = 1'b1;
    bus.i_valid = v;
    bus.i_flit  = f;
    tick();
    bus.i_valid = '0;
  endtask

  task automatic push(input logic [63:0] f, input logic [1:0] vc, input logic [4:0] port);
    exp_t e;
    e.flit = f;
    e.vc   = vc;
    e.port = port;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
    chk({tag, "_drain_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 64'(bus.o_valid), 64'd0);
    chk({tag, "_port"},  64'(bus.o_port_req), 64'd0);
    chk({tag, "_flit"},  bus.o_flit, 64'd0);
    chk({tag, "_ready"}, 64'(bus.o_vc_ready), 64'd3);
    chk({tag, "_error"}, 64'(error), 64'd0);
  endtask

  // Scoreboard monitor: every handshake must match the next queued expectation.
  always @(negedge noc_clk) begin : mon
    exp_t e;
    if (!noc_rst && bus.o_valid != '0 && bus.i_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_xfer: observed vc %b flit %0h, expected no transfer",
               bus.o_valid, bus.o_flit);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("xfer_flit", bus.o_flit, e.flit);
        chk("xfer_vc",   64'(bus.o_valid), 64'(e.vc));
        chk("xfer_port", 64'(bus.o_port_req), 64'(e.port));
      end
    end
  end

  initial begin
    logic [63:0] f0, f1, f2, f3, f4, f5, junk;
    noc_rst     = 1'b1;
    bus.i_valid = '0;
    bus.i_flit  = '0;
    bus.i_ready = 1'b0;
    cur_x = 4'd1;
    cur_y = 4'd1;
    tick();
    tick();
    chk_reset("rst0");
    noc_rst = 1'b0;
    tick();

    // Single head+tail flit routed East.
    bus.i_ready = 1'b1;
    f0 = mk(T_HT, 4'd3, 4'd1, 54'h11);
    push(f0, 2'b01, 5'b00010);
    wr(0, f0);
    chk("t1_valid", 64'(bus.o_valid), 64'd1);
    chk("t1_port",  64'(bus.o_port_req), 64'b00010);
    tick();
    chk("t1_empty_valid", 64'(bus.o_valid), 64'd0);
    chk("t1_ready", 64'(bus.o_vc_ready), 64'd3);

    // Two interleaved 3-flit packets; wormhole keeps each contiguous.
    cur_x = 4'd2;
    cur_y = 4'd2;
    f0 = mk(T_HEAD, 4'd2, 4'd0, 54'h20);
    f1 = mk(T_HEAD, 4'd0, 4'd2, 54'h30);
    f2 = mk(T_BODY, 4'd0, 4'd0, 54'h21);
    f3 = mk(T_BODY, 4'd0, 4'd0, 54'h31);
    f4 = mk(T_TAIL, 4'd0, 4'd0, 54'h22);
    f5 = mk(T_TAIL, 4'd0, 4'd0, 54'h32);
    push(f0, 2'b01, 5'b10000);
    push(f2, 2'b01, 5'b10000);
    push(f4, 2'b01, 5'b10000);
    push(f1, 2'b10, 5'b00100);
    push(f3, 2'b10, 5'b00100);
    push(f5, 2'b10, 5'b00100);
    wr(0, f0);
    wr(1, f1);
    wr(0, f2);
    wr(1, f3);
    wr(0, f4);
    wr(1, f5);
    drain("t2", 30);
    chk("t2_idle_valid", 64'(bus.o_valid), 64'd0);

    // Backpressure: presented flit stays stable, FIFO fills, overflow drops.
    bus.i_ready = 1'b0;
    f0 = mk(T_HEAD, 4'd2, 4'd3, 54'h40);
    f1 = mk(T_BODY, 4'd0, 4'd0, 54'h41);
    f2 = mk(T_BODY, 4'd0, 4'd0, 54'h42);
    f3 = mk(T_TAIL, 4'd0, 4'd0, 54'h43);
    junk = mk(T_BODY, 4'd0, 4'd0, 54'h4f);
    push(f0, 2'b10, 5'b01000);
    push(f1, 2'b10, 5'b01000);
    push(f2, 2'b10, 5'b01000);
    push(f3, 2'b10, 5'b01000);
    wr(1, f0);
    chk("t3_ready_after1", 64'(bus.o_vc_ready), 64'd3);
    wr(1, f1);
    chk("t3_ready_after2", 64'(bus.o_vc_ready), 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", 64'(bus.o_valid), 64'b10);
      chk("t3_hold_flit",  bus.o_flit, f0);
      chk("t3_hold_port",  64'(bus.o_port_req), 64'b01000);
      tick();
    end
    wr(1, f2);
    wr(1, f3);
    chk("t3_no_err_full", 64'(error), 64'd0);
    wr(1, junk);
    chk("t3_err_overflow", 64'(error), 64'd1);
    chk("t3_still_head", bus.o_flit, f0);
    bus.i_ready = 1'b1;
    drain("t3", 30);

    // Stray body flit on an idle VC is discarded and flagged.
    noc_rst = 1'b1;
    tick();
    chk_reset("rst1");
    noc_rst = 1'b0;
    tick();
    wr(0, mk(T_BODY, 4'd1, 4'd1, 54'h50));
    chk("t4_no_present", 64'(bus.o_valid), 64'd0);
    tick();
    chk("t4_error", 64'(error), 64'd1);
    chk("t4_valid", 64'(bus.o_valid), 64'd0);
    f0 = mk(T_HT, 4'd2, 4'd2, 54'h51);
    push(f0, 2'b01, 5'b00001);
    wr(0, f0);
    drain("t4", 10);

    // Local route; locked VC0 runs dry while VC1 waits for VC0's tail.
    f0 = mk(T_HEAD, 4'd2, 4'd2, 54'h60);
    f1 = mk(T_HT,   4'd3, 4'd2, 54'h70);
    f2 = mk(T_TAIL, 4'd0, 4'd0, 54'h61);
    push(f0, 2'b01, 5'b00001);
    wr(0, f0);
    chk("t5_valid", 64'(bus.o_valid), 64'd1);
    chk("t5_port",  64'(bus.o_port_req), 64'b00001);
    wr(1, f1);
    for (int i = 0; i < 3; i++) begin
      chk("t5_dry_valid", 64'(bus.o_valid), 64'd0);
      chk("t5_dry_port",  64'(bus.o_port_req), 64'b00001);
      tick();
    end
    push(f2, 2'b01, 5'b00001);
    push(f1, 2'b10, 5'b00010);
    wr(0, f2);
    drain("t5", 20);

    // Asynchronous reset in the middle of a packet.
    f0 = mk(T_HEAD, 4'd0, 4'd2, 54'h80);
    f1 = mk(T_BODY, 4'd0, 4'd0, 54'h81);
    push(f0, 2'b01, 5'b00100);
    wr(0, f0);
    wr(0, f1);
    bus.i_ready = 1'b0;
    #1;
    chk("t6_pre_valid", 64'(bus.o_valid), 64'd1);
    chk("t6_pre_flit",  bus.o_flit, f1);
    chk("t6_pre_port",  64'(bus.o_port_req), 64'b00100);
    #1;
    noc_rst = 1'b1;
    #1;
    chk_reset("t6_async");
    tick();
    noc_rst = 1'b0;
    bus.i_ready = 1'b1;
    f2 = mk(T_HT, 4'd2, 4'd3, 54'h90);
    push(f2, 2'b10, 5'b01000);
    wr(1, f2);
    drain("t6", 10);
    chk("t6_end_valid", 64'(bus.o_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
